// File: rtl/vc_input_fifo_if.sv
// rtl/vc_input_fifo_if.sv - link-side and allocator-side signals of the VC input FIFO
interface vc_input_fifo_if #(
  parameter int DATAW = 32,
  parameter int NVC   = 4
);
  localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1;

  logic [DATAW-1:0] idata;
  logic             wr_en;
  logic [VCW-1:0]   wr_vc;
  logic             rd_en;
  logic [VCW-1:0]   rd_vc;
  logic [DATAW-1:0] odata;
  logic [NVC-1:0]   empty;
  logic [NVC-1:0]   full;
  logic [NVC-1:0]   ordy;
  logic [NVC-1:0]   pkt_rdy;
  logic             err_ovf;
  logic             err_udf;

  // Link receiver / allocator side drives requests and observes status
  modport master (
    output idata, wr_en, wr_vc, rd_en, rd_vc,
    input  odata, empty, full, ordy, pkt_rdy, err_ovf, err_udf
  );

  // The FIFO itself
  modport slave (
    input  idata, wr_en, wr_vc, rd_en, rd_vc,
    output odata, empty, full, ordy, pkt_rdy, err_ovf, err_udf
  );
endinterface

// File: rtl/vc_input_fifo.sv
// rtl/vc_input_fifo.sv - multi-VC circular flit buffer with packet tracking and sticky errors
module vc_input_fifo #(
  parameter int DATAW    = 32,
  parameter int DEPTH    = 8,
  parameter int NVC      = 4,
  parameter int PKTLEN   = 4,
  parameter int TAIL_BIT = 31
) (
  input logic             clk,
  input logic             rst_,
  vc_input_fifo_if.slave  bus
);
  localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (NVC * DEPTH > 1) ? $clog2(NVC * DEPTH) : 1;

  localparam logic [VCW:0]   NVC_LIM  = (VCW + 1)'(NVC);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_PKT  = CW'(PKTLEN);

  // Flit storage, one DEPTH-sized region per VC; contents are never reset
  logic [DATAW-1:0] mem [NVC*DEPTH];

  logic [PW-1:0] wr_ptr [NVC];
  logic [PW-1:0] rd_ptr [NVC];
  logic [CW-1:0] cnt    [NVC];
  logic [CW-1:0] pcnt   [NVC];
  logic          err_ovf_q;
  logic          err_udf_q;

  logic             wr_vc_ok;
  logic             rd_vc_ok;
  logic [VCW-1:0]   wr_idx;
  logic [VCW-1:0]   rd_idx;
  logic             rd_empty;
  logic             wr_full;
  logic             rd_ok;
  logic             wr_ok;
  logic             rd_tail;
  logic             wr_tail;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    wr_addr;
  logic [DATAW-1:0] head;
  logic [NVC-1:0]   wr_hit;
  logic [NVC-1:0]   rd_hit;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Decode requests: out-of-range VCs are clamped to 0 and treated as rejected
  always_comb begin
    wr_vc_ok = ({1'b0, bus.wr_vc} < NVC_LIM);
    rd_vc_ok = ({1'b0, bus.rd_vc} < NVC_LIM);
    wr_idx   = wr_vc_ok ? bus.wr_vc : '0;
    rd_idx   = rd_vc_ok ? bus.rd_vc : '0;
    rd_empty = ~rd_vc_ok | (cnt[rd_idx] == '0);
    wr_full  = (cnt[wr_idx] == CNT_FULL);
    rd_ok    = bus.rd_en & ~rd_empty;
    // A full VC takes a write only when the same VC is popped this cycle
    wr_ok    = bus.wr_en & wr_vc_ok & (~wr_full | (rd_ok & (rd_idx == wr_idx)));
    rd_addr  = AW'(rd_idx) * AW'(DEPTH) + AW'(rd_ptr[rd_idx]);
    wr_addr  = AW'(wr_idx) * AW'(DEPTH) + AW'(wr_ptr[wr_idx]);
    head     = mem[rd_addr];
    rd_tail  = head[TAIL_BIT];
    wr_tail  = bus.idata[TAIL_BIT];
    bus.odata = rd_empty ? '0 : head;
  end

  // One-hot per-VC accept strobes so each queue updates independently
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int v = 0; v < NVC; v++) begin
      wr_hit[v] = wr_ok & (wr_idx == VCW'(v));
      rd_hit[v] = rd_ok & (rd_idx == VCW'(v));
    end
  end

  // Per-VC status flags derived from the occupancy and tail counters
  always_comb begin
    bus.empty   = '0;
    bus.full    = '0;
    bus.ordy    = '0;
    bus.pkt_rdy = '0;
    for (int v = 0; v < NVC; v++) begin
      bus.empty[v]   = (cnt[v] == '0);
      bus.full[v]    = (cnt[v] == CNT_FULL);
      bus.ordy[v]    = ((CNT_FULL - cnt[v]) >= CNT_PKT);
      bus.pkt_rdy[v] = (pcnt[v] != '0);
    end
    bus.err_ovf = err_ovf_q;
    bus.err_udf = err_udf_q;
  end

  // Flit write; suppressed on the reset edge so a discarded packet leaves no trace
  always_ff @(posedge clk) begin
    if (!rst_ && wr_ok) begin
      mem[wr_addr] <= bus.idata;
    end
  end

  // Pointers, occupancy, tail counts and sticky error flags
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
        pcnt[v]   <= '0;
      end
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (wr_hit[v]) begin
          wr_ptr[v] <= ptr_next(wr_ptr[v]);
        end
        if (rd_hit[v]) begin
          rd_ptr[v] <= ptr_next(rd_ptr[v]);
        end
        if (wr_hit[v] && !rd_hit[v]) begin
          cnt[v] <= cnt[v] + 1'b1;
        end else if (rd_hit[v] && !wr_hit[v]) begin
          cnt[v] <= cnt[v] - 1'b1;
        end
        if ((wr_hit[v] && wr_tail) && !(rd_hit[v] && rd_tail)) begin
          pcnt[v] <= pcnt[v] + 1'b1;
        end else if ((rd_hit[v] && rd_tail) && !(wr_hit[v] && wr_tail)) begin
          pcnt[v] <= pcnt[v] - 1'b1;
        end
      end
      if (bus.wr_en && !wr_ok) begin
        err_ovf_q <= 1'b1;
      end
      if (bus.rd_en && !rd_ok) begin
        err_udf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vc_input_fifo.sv
// tb/tb_vc_input_fifo.sv - directed-vector bench for vc_input_fifo
module tb_vc_input_fifo;
  logic clk = 1'b0;
  logic rst_;
  int   nvec = 0;
  int   nmis = 0;

  vc_input_fifo_if #(.DATAW(32), .NVC(4)) bus ();

  vc_input_fifo #(
    .DATAW(32), .DEPTH(8), .NVC(4), .PKTLEN(4), .TAIL_BIT(31)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given request, sampled 1 time unit after the edge
  task automatic cyc(input logic we, input logic [1:0] wv, input logic [31:0] d,
                     input logic re, input logic [1:0] rv);
    bus.wr_en = we;
    bus.wr_vc = wv;
    bus.idata = d;
    bus.rd_en = re;
    bus.rd_vc = rv;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  logic [31:0] exp5 [8];
  logic [31:0] p7   [5];

  initial begin
    exp5 = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h8000_0007, 32'h8000_0008};
    p7   = '{32'h11, 32'h12, 32'h8000_0013, 32'h14, 32'h8000_0015};
    bus.idata = '0;
    bus.wr_en = 1'b0;
    bus.wr_vc = '0;
    bus.rd_en = 1'b0;
    bus.rd_vc = '0;
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;

    chk("rst_empty",   bus.empty,   4'b1111);
    chk("rst_full",    bus.full,    4'b0000);
    chk("rst_ordy",    bus.ordy,    4'b1111);
    chk("rst_pkt_rdy", bus.pkt_rdy, 4'b0000);
    chk("rst_odata",   bus.odata,   32'h0);
    chk("rst_err_ovf", bus.err_ovf, 1'b0);
    chk("rst_err_udf", bus.err_udf, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 2'd2, (k == 8) ? 32'h8000_0007 : 32'(k - 1), 1'b0, 2'd2);
      chk("fill_ordy2",  bus.ordy[2],    (k <= 4));
      chk("fill_full2",  bus.full[2],    (k == 8));
      chk("fill_pkt2",   bus.pkt_rdy[2], (k == 8));
      chk("fill_empty2", bus.empty[2],   1'b0);
    end

    cyc(1'b1, 2'd2, 32'h99, 1'b0, 2'd2);
    chk("ovf_err",   bus.err_ovf, 1'b1);
    chk("ovf_full2", bus.full[2], 1'b1);
    chk("ovf_udf",   bus.err_udf, 1'b0);
    chk("ovf_head",  bus.odata,   32'h0);

    cyc(1'b1, 2'd2, 32'h8000_0008, 1'b1, 2'd2);
    chk("rw_head",  bus.odata,      32'h1);
    chk("rw_full2", bus.full[2],    1'b1);
    chk("rw_pkt2",  bus.pkt_rdy[2], 1'b1);
    chk("rw_ovf",   bus.err_ovf,    1'b1);
    chk("rw_udf",   bus.err_udf,    1'b0);

    for (int i = 0; i < 8; i++) begin
      chk("wrap_data", bus.odata, exp5[i]);
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
      chk("wrap_pkt2", bus.pkt_rdy[2], (i < 7));
    end
    chk("wrap_empty2", bus.empty[2], 1'b1);
    chk("wrap_full2",  bus.full[2],  1'b0);
    chk("wrap_udf",    bus.err_udf,  1'b0);

    cyc(1'b1, 2'd0, 32'hA0, 1'b1, 2'd1);
    chk("il_udf",    bus.err_udf, 1'b1);
    chk("il_odata1", bus.odata,   32'h0);
    chk("il_empty",  bus.empty,   4'b1110);
    cyc(1'b1, 2'd3, 32'hA3, 1'b1, 2'd1);
    chk("il_empty3", bus.empty,   4'b0110);
    bus.rd_vc = 2'd0;
    #1;
    chk("il_head0", bus.odata, 32'hA0);
    bus.rd_vc = 2'd3;
    #1;
    chk("il_head3", bus.odata, 32'hA3);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'd1, p7[i], 1'b0, 2'd1);
    end
    chk("pk_pkt1",  bus.pkt_rdy[1], 1'b1);
    chk("pk_ordy1", bus.ordy[1],    1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("pk_data", bus.odata, p7[i]);
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      chk("pk_pkt1_pop", bus.pkt_rdy[1], (i < 4));
    end
    chk("pk_empty1", bus.empty[1], 1'b1);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'd0, 32'hB0 + 32'(i), 1'b0, 2'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 2'd3, 32'hC0 + 32'(i), 1'b0, 2'd0);
    end
    chk("pre_rst_ordy",  bus.ordy,  4'b1110);
    chk("pre_rst_empty", bus.empty, 4'b0110);

    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    chk("mid_empty",   bus.empty,   4'b1111);
    chk("mid_full",    bus.full,    4'b0000);
    chk("mid_ordy",    bus.ordy,    4'b1111);
    chk("mid_pkt_rdy", bus.pkt_rdy, 4'b0000);
    chk("mid_odata",   bus.odata,   32'h0);
    chk("mid_err_ovf", bus.err_ovf, 1'b0);
    chk("mid_err_udf", bus.err_udf, 1'b0);

    cyc(1'b1, 2'd0, 32'hAB, 1'b0, 2'd0);
    chk("post_head0", bus.odata, 32'hAB);
    chk("post_empty", bus.empty, 4'b1110);

    cyc(1'b1, 2'd1, 32'h55, 1'b1, 2'd1);
    chk("nobyp_udf",   bus.err_udf,  1'b1);
    chk("nobyp_empty", bus.empty[1], 1'b0);
    chk("nobyp_head1", bus.odata,    32'h55);
    chk("nobyp_ovf",   bus.err_ovf,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
